// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter: exception codes,
// CP0 register addresses, the exception vector and FSM state encoding.
package except_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Exception flag bit positions inside exc_flags_i.
    localparam int FLAG_OV   = 0;
    localparam int FLAG_BP   = 1;
    localparam int FLAG_SYS  = 2;
    localparam int FLAG_RI   = 3;
    localparam int FLAG_ERET = 4;

endpackage

// File: rtl/except_ctrl_addr_align_chk.sv
// Combinational data-address alignment check producing AdEL/AdES for the
// load/store currently in MEM.
module addr_align_chk (
    input  logic       mem_rd_i,
    input  logic       mem_wr_i,
    input  logic [1:0] mem_size_i,
    input  logic [1:0] addr_lo_i,
    output logic       adel_o,
    output logic       ades_o
);
    logic misaligned;

    // Byte accesses can never be misaligned; size 3 is not a legal access.
    assign misaligned = ((mem_size_i == 2'd1) && addr_lo_i[0]) ||
                        ((mem_size_i == 2'd2) && (addr_lo_i != 2'b00));

    assign adel_o = mem_rd_i && misaligned;
    assign ades_o = mem_wr_i && misaligned;
endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks one exception by priority and commits it
// to CP0 for exactly one cycle together with a pipeline flush and redirect PC.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              in_delayslot_i,
    input  logic [4:0]        exc_flags_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [31:0]       cp0_status_i,
    input  logic [31:0]       cp0_cause_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    input  logic              wb_cp0_we_i,
    input  logic [4:0]        wb_cp0_waddr_i,
    input  logic [DATA_W-1:0] wb_cp0_data_i,
    output logic              mem_kill_o,
    output logic [31:0]       excepttype_o,
    output logic [DATA_W-1:0] exc_pc_o,
    output logic              exc_delayslot_o,
    output logic [DATA_W-1:0] bad_addr_o,
    output logic              flush_o,
    output logic [DATA_W-1:0] newpc_o
);
    logic [1:0]        state_q, state_d;
    logic              int_pend_q, int_pend_d;
    logic [31:0]       type_q, type_d;
    logic [DATA_W-1:0] pc_q, pc_d, bad_q, bad_d, newpc_q, newpc_d;
    logic              ds_q, ds_d;

    logic [31:0]       status_eff;
    logic [DATA_W-1:0] epc_eff;
    logic              int_cond, int_take, adel_data, ades_data;
    logic [31:0]       sel_code;
    logic [DATA_W-1:0] sel_bad;
    logic              exc_any, commit_go, in_commit;
    logic              unused_bits;

    // Forward an MTC0 sitting in WB so ERET and interrupt masking see it now.
    assign status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS)
                        ? wb_cp0_data_i[31:0] : cp0_status_i;
    assign epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)
                        ? wb_cp0_data_i : cp0_epc_i;

    assign int_cond = status_eff[0] && !status_eff[1] &&
                      ((cp0_cause_i[15:8] & status_eff[15:8]) != 8'h00);
    assign int_take = valid_i && (int_cond || int_pend_q);

    addr_align_chk u_align (
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .mem_size_i (mem_size_i),
        .addr_lo_i  (mem_addr_i[1:0]),
        .adel_o     (adel_data),
        .ades_o     (ades_data)
    );

    always_comb begin
        sel_code = EXC_NONE;
        sel_bad  = '0;
        if (int_take) begin
            sel_code = EXC_INT;
        end else if (pc_i[1:0] != 2'b00) begin
            sel_code = EXC_ADEL;
            sel_bad  = pc_i;
        end else if (exc_flags_i[FLAG_RI]) begin
            sel_code = EXC_RI;
        end else if (exc_flags_i[FLAG_OV]) begin
            sel_code = EXC_OV;
        end else if (exc_flags_i[FLAG_SYS]) begin
            sel_code = EXC_SYS;
        end else if (exc_flags_i[FLAG_BP]) begin
            sel_code = EXC_BP;
        end else if (exc_flags_i[FLAG_ERET]) begin
            sel_code = EXC_ERET;
        end else if (adel_data) begin
            sel_code = EXC_ADEL;
            sel_bad  = mem_addr_i;
        end else if (ades_data) begin
            sel_code = EXC_ADES;
            sel_bad  = mem_addr_i;
        end
    end

    assign exc_any    = (sel_code != EXC_NONE);
    assign mem_kill_o = exc_any;
    assign commit_go  = (state_q == ST_IDLE) && exc_any && !stall_i;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = commit_go ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_d = ST_DRAIN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A stalled pending interrupt must survive the condition dropping.
    always_comb begin
        int_pend_d = int_pend_q;
        if (commit_go && sel_code == EXC_INT) int_pend_d = 1'b0;
        else if (int_cond)                    int_pend_d = 1'b1;
        else if (!stall_i)                    int_pend_d = 1'b0;
    end

    always_comb begin
        type_d  = type_q;
        pc_d    = pc_q;
        ds_d    = ds_q;
        bad_d   = bad_q;
        newpc_d = newpc_q;
        if (commit_go) begin
            type_d  = sel_code;
            pc_d    = pc_i;
            ds_d    = in_delayslot_i;
            bad_d   = sel_bad;
            newpc_d = (sel_code == EXC_ERET) ? epc_eff : DATA_W'(EXC_VECTOR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            int_pend_q <= 1'b0;
            type_q     <= '0;
            pc_q       <= '0;
            ds_q       <= 1'b0;
            bad_q      <= '0;
            newpc_q    <= '0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            type_q     <= type_d;
            pc_q       <= pc_d;
            ds_q       <= ds_d;
            bad_q      <= bad_d;
            newpc_q    <= newpc_d;
        end
    end

    assign in_commit       = (state_q == ST_COMMIT);
    assign excepttype_o    = in_commit ? type_q  : '0;
    assign exc_pc_o        = in_commit ? pc_q    : '0;
    assign exc_delayslot_o = in_commit && ds_q;
    assign bad_addr_o      = in_commit ? bad_q   : '0;
    assign flush_o         = in_commit;
    assign newpc_o         = in_commit ? newpc_q : '0;

    assign unused_bits = ^{cp0_cause_i[31:16], cp0_cause_i[7:0],
                           status_eff[31:16], status_eff[7:2]};
endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: per-cycle expected CP0/flush outputs from a
// behavioural model are queued and checked by an independent monitor.
module tb_except_ctrl;

    typedef struct {
        logic        rst, stall, valid, ds, rd, wr, we;
        logic [31:0] pc, addr, status, cause, epc, wdata;
        logic [4:0]  flags, waddr;
        logic [1:0]  size;
    } stim_t;

    typedef struct packed {
        logic [31:0] typ;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        flush;
        logic [31:0] newpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall_i, valid_i, in_delayslot_i, mem_rd_i, mem_wr_i, wb_cp0_we_i;
    logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
    logic [4:0]  exc_flags_i, wb_cp0_waddr_i;
    logic [1:0]  mem_size_i;
    logic        mem_kill_o, exc_delayslot_o, flush_o;
    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, newpc_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference-model state: pending interrupt and cycles until the arbiter can commit again.
    bit   m_pend = 0;
    int   m_busy = 0;

    except_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .exc_flags_i(exc_flags_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
        .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i), .mem_kill_o(mem_kill_o), .excepttype_o(excepttype_o),
        .exc_pc_o(exc_pc_o), .exc_delayslot_o(exc_delayslot_o), .bad_addr_o(bad_addr_o),
        .flush_o(flush_o), .newpc_o(newpc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    function automatic stim_t quiet();
        stim_t s;
        s.rst = 0; s.stall = 0; s.valid = 1; s.ds = 0; s.rd = 0; s.wr = 0; s.we = 0;
        s.pc = 32'h8000_0000; s.addr = 32'h0; s.status = 32'h0; s.cause = 32'h0;
        s.epc = 32'h0; s.wdata = 32'h0; s.flags = 5'b0; s.waddr = 5'd0; s.size = 2'd0;
        return s;
    endfunction

    function automatic bit misaligned(logic [1:0] size, logic [31:0] addr);
        return (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    // Apply one cycle of stimulus, predict the outcome and queue the expected outputs.
    task automatic step(input stim_t s);
        logic [31:0] status, epc, code, badv;
        bit          cond, commit;
        bit          act[9];
        logic [31:0] codes[9];
        logic [31:0] bads[9];
        exp_t        e;
        @(negedge clk);
        rst = s.rst; stall_i = s.stall; valid_i = s.valid; pc_i = s.pc;
        in_delayslot_i = s.ds; exc_flags_i = s.flags; mem_rd_i = s.rd; mem_wr_i = s.wr;
        mem_size_i = s.size; mem_addr_i = s.addr; cp0_status_i = s.status;
        cp0_cause_i = s.cause; cp0_epc_i = s.epc; wb_cp0_we_i = s.we;
        wb_cp0_waddr_i = s.waddr; wb_cp0_data_i = s.wdata;

        status = (s.we && s.waddr == 5'd12) ? s.wdata : s.status;
        epc    = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
        cond   = status[0] && !status[1] && ((s.cause[15:8] & status[15:8]) != 0);

        act[0] = s.valid && (cond || m_pend);     codes[0] = 32'h1; bads[0] = 0;
        act[1] = (s.pc % 4 != 0);                 codes[1] = 32'h4; bads[1] = s.pc;
        act[2] = s.flags[3];                      codes[2] = 32'ha; bads[2] = 0;
        act[3] = s.flags[0];                      codes[3] = 32'hc; bads[3] = 0;
        act[4] = s.flags[2];                      codes[4] = 32'h8; bads[4] = 0;
        act[5] = s.flags[1];                      codes[5] = 32'h9; bads[5] = 0;
        act[6] = s.flags[4];                      codes[6] = 32'he; bads[6] = 0;
        act[7] = s.rd && misaligned(s.size, s.addr); codes[7] = 32'h4; bads[7] = s.addr;
        act[8] = s.wr && misaligned(s.size, s.addr); codes[8] = 32'h5; bads[8] = s.addr;
        code = 0; badv = 0;
        for (int i = 8; i >= 0; i--) if (act[i]) begin code = codes[i]; badv = bads[i]; end

        e = '0;
        if (s.rst) begin
            m_pend = 0;
            m_busy = 0;
        end else begin
            commit = (m_busy == 0) && (code != 0) && !s.stall;
            if (commit) begin
                e.typ = code; e.pc = s.pc; e.ds = s.ds; e.bad = badv; e.flush = 1;
                e.newpc = (code == 32'he) ? epc : 32'hBFC0_0380;
            end
            if (commit && code == 32'h1) m_pend = 0;
            else if (cond)               m_pend = 1;
            else if (!s.stall)           m_pend = 0;
            m_busy = commit ? 2 : (m_busy > 0 ? m_busy - 1 : 0);
        end
        exp_q.push_back(e);

        #1;
        total++;
        if (mem_kill_o !== (code != 0)) begin
            bad++;
            $display("FAIL mem_kill cyc=%0d got=%b need=%b", cyc, mem_kill_o, code != 0);
        end
    endtask

    // Monitor: every cycle the DUT presents its CP0/flush outputs; compare against the queue head.
    always @(posedge clk) begin
        exp_t e, got;
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, newpc_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL outputs cyc=%0d got type=%h pc=%h ds=%b bad=%h flush=%b newpc=%h need type=%h pc=%h ds=%b bad=%h flush=%b newpc=%h",
                         cyc, got.typ, got.pc, got.ds, got.bad, got.flush, got.newpc,
                         e.typ, e.pc, e.ds, e.bad, e.flush, e.newpc);
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s = quiet();
        s.stall  = ($urandom_range(0, 99) < 20);
        s.valid  = ($urandom_range(0, 99) < 90);
        s.pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        if ($urandom_range(0, 99) < 5) s.pc[1:0] = 2'($urandom_range(1, 3));
        s.ds     = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) s.flags[i] = ($urandom_range(0, 99) < 5);
        s.rd     = ($urandom_range(0, 99) < 20);
        s.wr     = !s.rd && ($urandom_range(0, 99) < 20);
        s.size   = 2'($urandom_range(0, 2));
        s.addr   = $urandom();
        s.status = {16'h0, 8'($urandom_range(0, 255)), 6'h0,
                    1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 70)};
        if ($urandom_range(0, 99) < 10) s.cause[15:8] = 8'($urandom_range(1, 255));
        s.epc    = $urandom();
        s.we     = ($urandom_range(0, 99) < 20);
        case ($urandom_range(0, 3))
            0: s.waddr = 5'd12;
            1: s.waddr = 5'd13;
            2: s.waddr = 5'd14;
            default: s.waddr = 5'($urandom_range(0, 31));
        endcase
        s.wdata  = $urandom();
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1; stall_i = 0; valid_i = 0; pc_i = 0; in_delayslot_i = 0; exc_flags_i = 0;
        mem_rd_i = 0; mem_wr_i = 0; mem_size_i = 0; mem_addr_i = 0; cp0_status_i = 0;
        cp0_cause_i = 0; cp0_epc_i = 0; wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;

        s = quiet(); s.rst = 1;
        repeat (3) step(s);
        step(quiet());

        // Misaligned load word.
        s = quiet(); s.rd = 1; s.size = 2'd2; s.addr = 32'h8000_0102;
        step(s);
        repeat (2) step(quiet());

        // Overflow in a delay slot.
        s = quiet(); s.flags = 5'b00001; s.ds = 1; s.pc = 32'hBFC0_0104;
        step(s);
        repeat (2) step(quiet());

        // ERET with EPC forwarded from an MTC0 in WB.
        s = quiet(); s.flags = 5'b10000; s.epc = 32'h1000;
        s.we = 1; s.waddr = 5'd14; s.wdata = 32'h2000;
        step(s);
        repeat (2) step(quiet());

        // Interrupt held through a three-cycle stall.
        s = quiet(); s.status = 32'h0000_0401; s.cause = 32'h0000_0400; s.stall = 1;
        repeat (3) step(s);
        s.stall = 0;
        step(s);
        s = quiet();
        repeat (3) step(s);

        // RI and syscall together with a misaligned fetch PC.
        s = quiet(); s.flags = 5'b01100; s.pc = 32'h8000_1002;
        step(s);
        repeat (2) step(quiet());

        // Misaligned store half, then reset during the commit cycle.
        s = quiet(); s.wr = 1; s.size = 2'd1; s.addr = 32'h0000_0011;
        step(s);
        s = quiet(); s.rst = 1;
        step(s);
        s = quiet(); s.flags = 5'b00010;
        step(s);
        repeat (2) step(quiet());

        for (int n = 0; n < 600; n++) begin
            s = rand_stim();
            if ($urandom_range(0, 99) < 2) s.rst = 1;
            step(s);
        end
        repeat (3) step(quiet());

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d need=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
